// File: rtl/edge_arb_pkg.sv
// Shared types and helpers for the edge event arbiter.
package edge_arb_pkg;

    // Channel detector states; 2'b11 is unreachable and decodes to S0.
    localparam logic [1:0] S0 = 2'b00;
    localparam logic [1:0] S1 = 2'b01;
    localparam logic [1:0] S2 = 2'b10;

    localparam int MAX_CH = 16;

    typedef enum logic {
        A_IDLE  = 1'b0,
        A_OFFER = 1'b1
    } arb_state_t;

    // Round-robin pick: first set bit scanning ptr, ptr+1, ... modulo n.
    // Returns ptr when nothing is pending (caller only uses it when something is).
    function automatic logic [3:0] rr_pick(input logic [MAX_CH-1:0] pending,
                                           input logic [3:0]        ptr,
                                           input int                n);
        logic [3:0] idx;
        logic       found;
        int         j;
        idx   = ptr;
        found = 1'b0;
        for (int k = 0; k < MAX_CH; k++) begin
            if (k < n) begin
                j = (int'(ptr) + k) % n;
                if (!found && pending[j]) begin
                    idx   = 4'(j);
                    found = 1'b1;
                end
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/edge_event_arbiter_det.sv
// One channel's 0->1 pattern detector; hit pulses on the edge entering S2.
module edge_det_ch
    import edge_arb_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic a,
    output logic hit
);

    logic [1:0] state, state_nxt;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S0;
        else       state <= state_nxt;
    end

    // Next-state logic; disable parks the channel in S0.
    always_comb begin
        state_nxt = S0;
        if (enable) begin
            case (state)
                S0:      state_nxt = a ? S0 : S1;
                S1:      state_nxt = a ? S2 : S1;
                S2:      state_nxt = a ? S0 : S1;
                default: state_nxt = S0;
            endcase
        end
    end

    // S2 is never re-entered from itself, so next==S2 marks entry.
    assign hit = (state_nxt == S2);

endmodule

// File: rtl/edge_event_arbiter.sv
// Per-channel edge detectors feeding a one-deep pending queue, drained
// round-robin onto a single valid/ready event port.
module edge_event_arbiter
    import edge_arb_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [N_CH-1:0]         a_in,
    output logic                    evt_valid,
    input  logic                    evt_ready,
    output logic [$clog2(N_CH)-1:0] evt_ch,
    output logic [N_CH-1:0]         ovr,
    input  logic                    ovr_clr,
    output logic [CNT_W-1:0]        evt_total
);

    localparam int IW = $clog2(N_CH);

    logic [N_CH-1:0] hit, pending, consume;
    logic [IW-1:0]   rr_ptr, ch_pick, ch_nxt;
    logic            hs, valid_nxt;
    arb_state_t      state, state_nxt;

    genvar g;
    generate
        for (g = 0; g < N_CH; g++) begin : g_ch
            edge_det_ch u_det (
                .clk    (clk),
                .reset  (reset),
                .enable (enable),
                .a      (a_in[g]),
                .hit    (hit[g])
            );
        end
    endgenerate

    assign hs      = (state == A_OFFER) && evt_ready;
    assign consume = hs ? (N_CH'(1) << evt_ch) : '0;
    assign ch_pick = IW'(rr_pick(MAX_CH'(pending), 4'(rr_ptr), N_CH));

    // Arbiter state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= A_IDLE;
        else       state <= state_nxt;
    end

    // Arbiter next state: offer when anything is queued, return on handshake.
    always_comb begin
        state_nxt = state;
        if (state == A_IDLE) begin
            if (|pending) state_nxt = A_OFFER;
        end else begin
            if (evt_ready) state_nxt = A_IDLE;
        end
    end

    // Arbiter outputs (registered below): channel loads only when leaving idle.
    always_comb begin
        valid_nxt = (state_nxt == A_OFFER);
        ch_nxt    = evt_ch;
        if (state == A_IDLE && |pending) ch_nxt = ch_pick;
    end

    // Output registers; async reset drops an in-flight offer immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            evt_valid <= 1'b0;
            evt_ch    <= '0;
        end else begin
            evt_valid <= valid_nxt;
            evt_ch    <= ch_nxt;
        end
    end

    // Pending/overrun bookkeeping; a detection coinciding with its own
    // handshake is a fresh event, not an overrun, and overrun beats clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
            ovr     <= '0;
        end else begin
            pending <= (pending & ~consume) | hit;
            ovr     <= (ovr_clr ? '0 : ovr) | (hit & pending & ~consume);
        end
    end

    // Round-robin pointer and saturating delivered-event counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr    <= '0;
            evt_total <= '0;
        end else if (hs) begin
            rr_ptr <= (evt_ch == IW'(N_CH - 1)) ? '0 : evt_ch + 1'b1;
            if (~&evt_total) evt_total <= evt_total + 1'b1;
        end
    end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Self-checking bench: directed vector table, corner sequences and a random
// run compared against an event-level reference model.
module tb_edge_event_arbiter;

    localparam int N    = 4;
    localparam int CW   = 3;
    localparam int TMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b1;
    logic [N-1:0]  a_in = '0;
    logic          evt_valid;
    logic          evt_ready = 1'b0;
    logic [1:0]    evt_ch;
    logic [N-1:0]  ovr;
    logic          ovr_clr = 1'b0;
    logic [CW-1:0] evt_total;

    int n_assert = 0;
    int n_fail   = 0;
    int hs_q[$];

    // Reference model state: "armed" means the line was seen low with
    // detection enabled on the previous edge.
    bit [N-1:0] m_pend, m_ovr, m_armed;
    bit         m_valid;
    int         m_ch, m_rr, m_total;

    edge_event_arbiter #(.N_CH(N), .CNT_W(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .a_in      (a_in),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_ch    (evt_ch),
        .ovr       (ovr),
        .ovr_clr   (ovr_clr),
        .evt_total (evt_total)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_pend = '0; m_ovr = '0; m_armed = '0;
        m_valid = 1'b0; m_ch = 0; m_rr = 0; m_total = 0;
    endtask

    // One clock edge of the reference behaviour.
    task automatic model_edge();
        bit         hs;
        bit [N-1:0] det, oldp;
        hs   = m_valid && evt_ready;
        oldp = m_pend;
        for (int i = 0; i < N; i++) begin
            det[i]     = enable && a_in[i] && m_armed[i];
            m_armed[i] = enable && !a_in[i];
        end
        if (ovr_clr) m_ovr = '0;
        for (int i = 0; i < N; i++)
            if (det[i] && oldp[i] && !(hs && m_ch == i)) m_ovr[i] = 1'b1;
        if (hs) m_pend[m_ch] = 1'b0;
        m_pend |= det;
        if (hs) begin
            m_valid = 1'b0;
            m_rr    = (m_ch + 1) % N;
            if (m_total < TMAX) m_total++;
        end else if (!m_valid && oldp != 0) begin
            for (int k = N - 1; k >= 0; k--)
                if (oldp[(m_rr + k) % N]) m_ch = (m_rr + k) % N;
            m_valid = 1'b1;
        end
    endtask

    task automatic cmp_model();
        check("valid_vs_model", int'(evt_valid), int'(m_valid));
        check("ch_vs_model",    int'(evt_ch),    m_ch);
        check("ovr_vs_model",   int'(ovr),       int'(m_ovr));
        check("total_vs_model", int'(evt_total), m_total);
    endtask

    // Called just after an active edge: drive, log handshake, clock, compare.
    task automatic step(input logic [N-1:0] a, input logic en, input logic rdy,
                        input logic clr);
        a_in = a; enable = en; evt_ready = rdy; ovr_clr = clr;
        #1;
        if (evt_valid && evt_ready) hs_q.push_back(int'(evt_ch));
        @(posedge clk);
        model_edge();
        #1;
        cmp_model();
    endtask

    task automatic do_reset();
        reset = 1'b1; evt_ready = 1'b0; ovr_clr = 1'b0;
        model_clear();
        #1;
        check("rst_valid", int'(evt_valid), 0);
        check("rst_ch",    int'(evt_ch),    0);
        check("rst_ovr",   int'(ovr),       0);
        check("rst_total", int'(evt_total), 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    typedef struct {
        logic [N-1:0] a;
        logic         rdy;
        logic         ev;
        int           ech;
        int           etot;
    } vec_t;

    vec_t tbl[15];

    initial begin
        // Test 1 (ch0 0->1) and test 2 (ch2 pattern 0,1,1,0,1 -> two events).
        tbl[0]  = '{4'hF, 1'b0, 1'b0, 0, 0};
        tbl[1]  = '{4'hF, 1'b0, 1'b0, 0, 0};
        tbl[2]  = '{4'hE, 1'b0, 1'b0, 0, 0};
        tbl[3]  = '{4'hF, 1'b0, 1'b0, 0, 0};
        tbl[4]  = '{4'hF, 1'b0, 1'b1, 0, 0};
        tbl[5]  = '{4'hF, 1'b1, 1'b0, 0, 1};
        tbl[6]  = '{4'hF, 1'b1, 1'b0, 0, 1};
        tbl[7]  = '{4'hB, 1'b1, 1'b0, 0, 1};
        tbl[8]  = '{4'hF, 1'b1, 1'b0, 0, 1};
        tbl[9]  = '{4'hF, 1'b1, 1'b1, 2, 1};
        tbl[10] = '{4'hB, 1'b1, 1'b0, 2, 2};
        tbl[11] = '{4'hF, 1'b1, 1'b0, 2, 2};
        tbl[12] = '{4'hF, 1'b1, 1'b1, 2, 2};
        tbl[13] = '{4'hF, 1'b1, 1'b0, 2, 3};
        tbl[14] = '{4'hF, 1'b1, 1'b0, 2, 3};

        a_in = 4'hF;
        do_reset();
        for (int i = 0; i < 15; i++) begin
            step(tbl[i].a, 1'b1, tbl[i].rdy, 1'b0);
            check($sformatf("tbl%0d_valid", i), int'(evt_valid), int'(tbl[i].ev));
            check($sformatf("tbl%0d_ch", i),    int'(evt_ch),    tbl[i].ech);
            check($sformatf("tbl%0d_total", i), int'(evt_total), tbl[i].etot);
        end

        // Test 3: simultaneous detect, then ch1 before ch0 across the wrap.
        do_reset();
        hs_q.delete();
        step(4'h0, 1'b1, 1'b1, 1'b0);
        step(4'hF, 1'b1, 1'b1, 1'b0);
        repeat (9) step(4'hF, 1'b1, 1'b1, 1'b0);
        check("rr_order_n", hs_q.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < hs_q.size()) check($sformatf("rr_order%0d", i), hs_q[i], i);
        hs_q.delete();
        step(4'h0, 1'b1, 1'b1, 1'b0);
        step(4'h2, 1'b1, 1'b1, 1'b0);
        repeat (6) step(4'h3, 1'b1, 1'b1, 1'b0);
        check("wrap_n", hs_q.size(), 2);
        if (hs_q.size() == 2) begin
            check("wrap_first", hs_q[0], 1);
            check("wrap_second", hs_q[1], 0);
        end

        // Test 4: stalled consumer, ch1 re-triggered twice -> overrun, one delivery.
        do_reset();
        hs_q.delete();
        for (int i = 0; i < 20; i++) begin
            step((i == 1 || i == 3 || i == 5) ? 4'h2 : 4'h0, 1'b1, 1'b0, 1'b0);
            if (i >= 2) begin
                check("stall_valid", int'(evt_valid), 1);
                check("stall_ch",    int'(evt_ch),    1);
            end
        end
        check("ovr_set", int'(ovr), 2);
        step(4'h0, 1'b1, 1'b0, 1'b1);
        check("ovr_clr", int'(ovr), 0);
        repeat (6) step(4'h0, 1'b1, 1'b1, 1'b0);
        check("stall_deliv_n", hs_q.size(), 1);
        if (hs_q.size() == 1) check("stall_deliv_ch", hs_q[0], 1);

        // Test 5: saturation, then enable=0 still drains queued events.
        do_reset();
        hs_q.delete();
        for (int e = 0; e < 10; e++) begin
            step(4'h0, 1'b1, 1'b1, 1'b0);
            repeat (3) step(4'h1, 1'b1, 1'b1, 1'b0);
        end
        check("sat_deliv_n", hs_q.size(), 10);
        check("sat_total", int'(evt_total), TMAX);
        do_reset();
        hs_q.delete();
        step(4'h0, 1'b1, 1'b0, 1'b0);
        step(4'hC, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step((i % 2) ? 4'hF : 4'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step((i % 2) ? 4'hF : 4'h0, 1'b0, 1'b1, 1'b0);
        check("dis_deliv_n", hs_q.size(), 2);
        if (hs_q.size() == 2) begin
            check("dis_first", hs_q[0], 2);
            check("dis_second", hs_q[1], 3);
        end
        check("dis_idle", int'(evt_valid), 0);

        // Test 6: reset during a stalled offer, then clean restart from S0.
        do_reset();
        step(4'h0, 1'b1, 1'b0, 1'b0);
        step(4'h1, 1'b1, 1'b0, 1'b0);
        step(4'h1, 1'b1, 1'b0, 1'b0);
        check("pre_rst_valid", int'(evt_valid), 1);
        do_reset();
        step(4'h1, 1'b1, 1'b1, 1'b0);
        step(4'h1, 1'b1, 1'b1, 1'b0);
        check("post_rst_quiet", int'(evt_valid), 0);
        step(4'h0, 1'b1, 1'b1, 1'b0);
        step(4'h1, 1'b1, 1'b1, 1'b0);
        step(4'h1, 1'b1, 1'b0, 1'b0);
        check("post_rst_valid", int'(evt_valid), 1);
        check("post_rst_ch",    int'(evt_ch),    0);

        // Random run against the model.
        do_reset();
        for (int i = 0; i < 1500; i++)
            step(4'($urandom), ($urandom % 8) != 0, 1'($urandom),
                 ($urandom % 16) == 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
